commit_control: RTL and testbench
=================================

# commit_control

Parametrised in-order retirement controller at the ROB head: the successor to the single-cycle write-results logic. Each cycle it inspects the head entry and performs the architectural side effects. These are register-file write with a busy-clear check, condition-code update, branch resolution with a multi-cycle flush, store handshake with memory, and two-phase LDI/STI sequencing through an explicit FSM. It adds saturating performance counters and sits between the ROB, regfile, fetch unit, load/store buffer and branch predictor.

## Interface
- DATA_WIDTH, 16, width of result values and PCs
- TAG_WIDTH, 3, ROB address width
- FLUSH_CYCLES, 1, cycles flush stays asserted after a redirect (1..15)
- CNT_WIDTH, 32, perf counter width
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- head_valid  in  1  ROB head entry valid and complete
- head_opcode  in  lc3b_opcode  head opcode
- head_dest  in  lc3b_reg  dest register; nzp bits for BR
- head_value  in  DATA_WIDTH  result, or target PC for BR/TRAP
- head_predict  in  1  predicted-taken bit for BR
- head_addr  in  TAG_WIDTH  ROB index of head
- rat_tag  in  TAG_WIDTH  current RAT tag of head_dest
- trap_reg  in  DATA_WIDTH  link value written on TRAP
- dmem_resp  in  1  data memory write done
- rf_dest  out  lc3b_reg  regfile write index (= head_dest)
- rf_value  out  DATA_WIDTH  trap_reg on TRAP, else head_value
- rf_ld_value  out  1  write rf_value
- rf_ld_busy  out  1  clear busy (rat_tag == head_addr)
- rob_re  out  1  pop ROB head
- ldstr_re  out  1  pop load/store buffer
- dmem_write  out  1  data memory write request
- flush  out  1  squash younger state
- pcmux_sel  out  1  redirect fetch
- new_pc  out  DATA_WIDTH  redirect target (= head_value)
- pred_ld  out  1  update predictor
- pred_taken  out  1  resolved branch direction
- cnt_retired, cnt_branch, cnt_mispredict  out  CNT_WIDTH  perf counters

## Operation
- FSM states: RUN, LDI2, STI2, FLUSH. Reset → RUN, CC = 3'b010, flush counter 0, counters 0; all outputs 0.
- RUN, head_valid=1, by opcode:
  - ADD/AND/NOT/SHF/LEA/LDR/LDB: rf_ld_value, rf_ld_busy per tag match, CC load, rob_re.
  - JSR: same as above without CC load.
  - BR: taken = |(CC & head_dest). Assert pred_ld, pred_taken=taken, rob_re.
  - BR with taken != head_predict: also assert flush and pcmux_sel; if FLUSH_CYCLES>1 go to FLUSH.
  - TRAP: rf_ld_value, rf_ld_busy, rob_re, flush, pcmux_sel; FLUSH rule as BR.
  - STR/STB: dmem_write held; rob_re and ldstr_re equal dmem_resp.
  - LDI: rob_re only; → LDI2.
  - STI: rob_re only; → STI2.
  - Other opcodes: no action.
- LDI2: waits for head_valid; then behaves as a register-writing op with CC load, rob_re, → RUN.
- STI2: dmem_write held regardless of head_valid; on dmem_resp assert rob_re and ldstr_re, → RUN.
- FLUSH: flush=1 and all other outputs 0; held FLUSH_CYCLES-1 cycles, then → RUN.
- gencc: n = MSB, z = value==0, p otherwise; computed on rf_value.
- Counters:
  - cnt_retired increments on each rob_re.
  - cnt_branch increments on each BR retire.
  - cnt_mispredict increments on each BR redirect.
  - All counters saturate at all-ones.

## Timing
- All outputs are combinational from state and inputs in the same cycle; retire latency is 0 cycles from head_valid, except stores, which wait for dmem_resp.
- CC, FSM, flush counter and perf counters update on the rising clk edge; a BR sees the CC from instructions retired in earlier cycles only.
- flush overrides: when flush is asserted in RUN, the redirect's own rob_re still fires; in FLUSH, rob_re=0 even if head_valid.
- reset_n low for any state, including mid-STI2 with dmem_write high: next edge → RUN, and outputs drop in that cycle.
- A stalled store (no dmem_resp) holds dmem_write indefinitely; this is not a timeout.

## Structure
- lc3b_types gains commit_state_t (RUN, LDI2, STI2, FLUSH) and the FLUSH_CYCLES range constant.
- One sub-module, commit_cc_unit, reuses gencc, the 3-bit register and cccomp.
- Everything else lives in commit_control.

## Test plan
- ADD, dest R3, value 16'h8000, rat_tag==head_addr → rf_ld_value=1, rf_ld_busy=1, rob_re=1; next BR with nzp=100 is taken.
- BR predict=0, CC=z, nzp=010, FLUSH_CYCLES=3 → flush and pcmux_sel in cycle 0, new_pc=head_value; flush only in cycles 1–2; cnt_mispredict=1.
- STR with dmem_resp after 4 cycles → dmem_write high 5 cycles; rob_re and ldstr_re high only in the 5th.
- LDI then its second entry, value 0 → first cycle rob_re only; second cycle rf write, CC=z.
- STI, then reset_n=0 during STI2 → next cycle all outputs 0 and state RUN.
- Counters preset near saturation, CNT_WIDTH=4, 20 retires → cnt_retired=4'hF and holds.

Source files
------------

// File: rtl/commit_control_pkg.sv
// Shared LC-3b types for the commit stage: opcodes, register index,
// commit FSM states and the flush-length limits.
package commit_control_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDI2  = 2'd1,
    STI2  = 2'd2,
    FLUSH = 2'd3
  } commit_state_t;

  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 15;
  localparam int FLUSH_CNT_WIDTH  = 4;

  localparam lc3b_reg CC_RESET = 3'b010;

  // Opcodes that write the register file and also update the condition codes.
  function automatic logic writes_reg_and_cc(input lc3b_opcode op);
    logic w;
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA, OP_LDR, OP_LDB: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/commit_control_if.sv
// Bundle of ROB-head, regfile, fetch, memory and predictor signals seen by
// the commit controller (slave) and by its surroundings (master).
interface commit_control_if
  import commit_control_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 3,
  parameter int CNT_WIDTH  = 32
);
  logic                  head_valid;
  lc3b_opcode            head_opcode;
  lc3b_reg               head_dest;
  logic [DATA_WIDTH-1:0] head_value;
  logic                  head_predict;
  logic [TAG_WIDTH-1:0]  head_addr;
  logic [TAG_WIDTH-1:0]  rat_tag;
  logic [DATA_WIDTH-1:0] trap_reg;
  logic                  dmem_resp;

  lc3b_reg               rf_dest;
  logic [DATA_WIDTH-1:0] rf_value;
  logic                  rf_ld_value;
  logic                  rf_ld_busy;
  logic                  rob_re;
  logic                  ldstr_re;
  logic                  dmem_write;
  logic                  flush;
  logic                  pcmux_sel;
  logic [DATA_WIDTH-1:0] new_pc;
  logic                  pred_ld;
  logic                  pred_taken;
  logic [CNT_WIDTH-1:0]  cnt_retired;
  logic [CNT_WIDTH-1:0]  cnt_branch;
  logic [CNT_WIDTH-1:0]  cnt_mispredict;

  modport slave (
    input  head_valid, head_opcode, head_dest, head_value, head_predict,
           head_addr, rat_tag, trap_reg, dmem_resp,
    output rf_dest, rf_value, rf_ld_value, rf_ld_busy, rob_re, ldstr_re,
           dmem_write, flush, pcmux_sel, new_pc, pred_ld, pred_taken,
           cnt_retired, cnt_branch, cnt_mispredict
  );

  modport master (
    output head_valid, head_opcode, head_dest, head_value, head_predict,
           head_addr, rat_tag, trap_reg, dmem_resp,
    input  rf_dest, rf_value, rf_ld_value, rf_ld_busy, rob_re, ldstr_re,
           dmem_write, flush, pcmux_sel, new_pc, pred_ld, pred_taken,
           cnt_retired, cnt_branch, cnt_mispredict
  );
endinterface

// File: rtl/commit_control_cc_unit.sv
// Condition-code register for commit: derives nzp from the written value and
// compares the stored nzp against a branch's nzp mask.
module commit_cc_unit
  import commit_control_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cc_load,
  input  logic [DATA_WIDTH-1:0] cc_value,
  input  lc3b_reg               br_nzp,
  output logic                  br_taken
);

  lc3b_reg cc_d;
  lc3b_reg cc_q;

  function automatic lc3b_reg gencc(input logic [DATA_WIDTH-1:0] value);
    lc3b_reg nzp;
    if (value[DATA_WIDTH-1]) begin
      nzp = 3'b100;
    end else if (value == {DATA_WIDTH{1'b0}}) begin
      nzp = 3'b010;
    end else begin
      nzp = 3'b001;
    end
    return nzp;
  endfunction

  // Next condition code: new nzp on load, otherwise hold.
  always_comb begin
    cc_d = cc_q;
    if (cc_load) begin
      cc_d = gencc(cc_value);
    end else begin
      cc_d = cc_q;
    end
  end

  // Condition-code register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  // Branches only see codes retired in earlier cycles.
  assign br_taken = |(cc_q & br_nzp);

endmodule

// File: rtl/commit_control.sv
// In-order retirement controller at the ROB head: register writeback, CC
// update, branch resolution with flush, store handshake and LDI/STI sequencing.
module commit_control
  import commit_control_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int TAG_WIDTH    = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input logic             clk,
  input logic             reset_n,
  commit_control_if.slave bus
);

  localparam int FLUSH_LEN = (FLUSH_CYCLES < FLUSH_CYCLES_MIN) ? FLUSH_CYCLES_MIN :
                             (FLUSH_CYCLES > FLUSH_CYCLES_MAX) ? FLUSH_CYCLES_MAX :
                             FLUSH_CYCLES;

  logic                  head_valid_s;
  lc3b_opcode            head_opcode_s;
  lc3b_reg               head_dest_s;
  logic [DATA_WIDTH-1:0] head_value_s;
  logic                  head_predict_s;
  logic [TAG_WIDTH-1:0]  head_addr_s;
  logic [TAG_WIDTH-1:0]  rat_tag_s;
  logic [DATA_WIDTH-1:0] trap_reg_s;
  logic                  dmem_resp_s;
  logic                  tag_match_s;
  logic                  br_taken_s;

  commit_state_t              state_d, state_q;
  logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_d, flush_cnt_q;
  logic [CNT_WIDTH-1:0]       cnt_retired_d, cnt_retired_q;
  logic [CNT_WIDTH-1:0]       cnt_branch_d, cnt_branch_q;
  logic [CNT_WIDTH-1:0]       cnt_mispredict_d, cnt_mispredict_q;

  lc3b_reg               rf_dest_s;
  logic [DATA_WIDTH-1:0] rf_value_s;
  logic                  rf_ld_value_s;
  logic                  rf_ld_busy_s;
  logic                  rob_re_s;
  logic                  ldstr_re_s;
  logic                  dmem_write_s;
  logic                  flush_s;
  logic                  pcmux_sel_s;
  logic [DATA_WIDTH-1:0] new_pc_s;
  logic                  pred_ld_s;
  logic                  pred_taken_s;
  logic                  cc_load_s;
  logic                  branch_s;
  logic                  redirect_s;

  assign head_valid_s   = bus.head_valid;
  assign head_opcode_s  = bus.head_opcode;
  assign head_dest_s    = bus.head_dest;
  assign head_value_s   = bus.head_value;
  assign head_predict_s = bus.head_predict;
  assign head_addr_s    = bus.head_addr;
  assign rat_tag_s      = bus.rat_tag;
  assign trap_reg_s     = bus.trap_reg;
  assign dmem_resp_s    = bus.dmem_resp;
  assign tag_match_s    = (rat_tag_s == head_addr_s);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  commit_cc_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cc (
    .clk      (clk),
    .reset_n  (reset_n),
    .cc_load  (cc_load_s),
    .cc_value (rf_value_s),
    .br_nzp   (head_dest_s),
    .br_taken (br_taken_s)
  );

  // Next-state and all retirement outputs; reset forces every output low.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    rf_dest_s     = 3'b000;
    rf_value_s    = {DATA_WIDTH{1'b0}};
    rf_ld_value_s = 1'b0;
    rf_ld_busy_s  = 1'b0;
    rob_re_s      = 1'b0;
    ldstr_re_s    = 1'b0;
    dmem_write_s  = 1'b0;
    flush_s       = 1'b0;
    pcmux_sel_s   = 1'b0;
    new_pc_s      = {DATA_WIDTH{1'b0}};
    pred_ld_s     = 1'b0;
    pred_taken_s  = 1'b0;
    cc_load_s     = 1'b0;
    branch_s      = 1'b0;
    redirect_s    = 1'b0;

    if (!reset_n) begin
      state_d     = RUN;
      flush_cnt_d = {FLUSH_CNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        RUN: begin
          if (head_valid_s) begin
            rf_dest_s  = head_dest_s;
            rf_value_s = (head_opcode_s == OP_TRAP) ? trap_reg_s : head_value_s;
            if (writes_reg_and_cc(head_opcode_s)) begin
              rf_ld_value_s = 1'b1;
              rf_ld_busy_s  = tag_match_s;
              cc_load_s     = 1'b1;
              rob_re_s      = 1'b1;
            end else begin
              case (head_opcode_s)
                OP_JSR: begin
                  rf_ld_value_s = 1'b1;
                  rf_ld_busy_s  = tag_match_s;
                  rob_re_s      = 1'b1;
                end
                OP_BR: begin
                  pred_ld_s    = 1'b1;
                  pred_taken_s = br_taken_s;
                  rob_re_s     = 1'b1;
                  branch_s     = 1'b1;
                  redirect_s   = (br_taken_s != head_predict_s);
                end
                OP_TRAP: begin
                  rf_ld_value_s = 1'b1;
                  rf_ld_busy_s  = tag_match_s;
                  rob_re_s      = 1'b1;
                  redirect_s    = 1'b1;
                end
                OP_STR, OP_STB: begin
                  dmem_write_s = 1'b1;
                  rob_re_s     = dmem_resp_s;
                  ldstr_re_s   = dmem_resp_s;
                end
                OP_LDI: begin
                  rob_re_s = 1'b1;
                  state_d  = LDI2;
                end
                OP_STI: begin
                  rob_re_s = 1'b1;
                  state_d  = STI2;
                end
                default: begin
                  state_d = RUN;
                end
              endcase
            end
            // The redirecting instruction itself still retires this cycle.
            if (redirect_s) begin
              flush_s     = 1'b1;
              pcmux_sel_s = 1'b1;
              new_pc_s    = head_value_s;
              if (FLUSH_LEN > 1) begin
                state_d     = FLUSH;
                flush_cnt_d = FLUSH_CNT_WIDTH'(FLUSH_LEN - 1);
              end else begin
                state_d = RUN;
              end
            end else begin
              flush_cnt_d = flush_cnt_q;
            end
          end else begin
            state_d = RUN;
          end
        end
        LDI2: begin
          if (head_valid_s) begin
            rf_dest_s     = head_dest_s;
            rf_value_s    = head_value_s;
            rf_ld_value_s = 1'b1;
            rf_ld_busy_s  = tag_match_s;
            cc_load_s     = 1'b1;
            rob_re_s      = 1'b1;
            state_d       = RUN;
          end else begin
            state_d = LDI2;
          end
        end
        STI2: begin
          dmem_write_s = 1'b1;
          if (dmem_resp_s) begin
            rob_re_s   = 1'b1;
            ldstr_re_s = 1'b1;
            state_d    = RUN;
          end else begin
            state_d = STI2;
          end
        end
        FLUSH: begin
          flush_s = 1'b1;
          if (flush_cnt_q <= FLUSH_CNT_WIDTH'(1)) begin
            state_d     = RUN;
            flush_cnt_d = {FLUSH_CNT_WIDTH{1'b0}};
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d     = RUN;
          flush_cnt_d = {FLUSH_CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_comb begin
    cnt_retired_d    = cnt_retired_q;
    cnt_branch_d     = cnt_branch_q;
    cnt_mispredict_d = cnt_mispredict_q;
    if (rob_re_s) begin
      cnt_retired_d = sat_inc(cnt_retired_q);
    end else begin
      cnt_retired_d = cnt_retired_q;
    end
    if (branch_s) begin
      cnt_branch_d = sat_inc(cnt_branch_q);
    end else begin
      cnt_branch_d = cnt_branch_q;
    end
    if (branch_s && redirect_s) begin
      cnt_mispredict_d = sat_inc(cnt_mispredict_q);
    end else begin
      cnt_mispredict_d = cnt_mispredict_q;
    end
  end

  // FSM, flush countdown and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= RUN;
      flush_cnt_q      <= {FLUSH_CNT_WIDTH{1'b0}};
      cnt_retired_q    <= {CNT_WIDTH{1'b0}};
      cnt_branch_q     <= {CNT_WIDTH{1'b0}};
      cnt_mispredict_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      cnt_retired_q    <= cnt_retired_d;
      cnt_branch_q     <= cnt_branch_d;
      cnt_mispredict_q <= cnt_mispredict_d;
    end
  end

  assign bus.rf_dest        = rf_dest_s;
  assign bus.rf_value       = rf_value_s;
  assign bus.rf_ld_value    = rf_ld_value_s;
  assign bus.rf_ld_busy     = rf_ld_busy_s;
  assign bus.rob_re         = rob_re_s;
  assign bus.ldstr_re       = ldstr_re_s;
  assign bus.dmem_write     = dmem_write_s;
  assign bus.flush          = flush_s;
  assign bus.pcmux_sel      = pcmux_sel_s;
  assign bus.new_pc         = new_pc_s;
  assign bus.pred_ld        = pred_ld_s;
  assign bus.pred_taken     = pred_taken_s;
  assign bus.cnt_retired    = cnt_retired_q;
  assign bus.cnt_branch     = cnt_branch_q;
  assign bus.cnt_mispredict = cnt_mispredict_q;

endmodule

// File: tb/tb_commit_control.sv
// Directed bench for commit_control: one instance with a 3-cycle flush, a
// second with 4-bit counters fed the same head stream for saturation.
module tb_commit_control;
  import commit_control_pkg::*;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   vectors;
  int   miscompares;

  commit_control_if #(.DATA_WIDTH(16), .TAG_WIDTH(3), .CNT_WIDTH(32)) if_a ();
  commit_control_if #(.DATA_WIDTH(16), .TAG_WIDTH(3), .CNT_WIDTH(4))  if_b ();

  commit_control #(.DATA_WIDTH(16), .TAG_WIDTH(3), .FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset_n(rst_n_a), .bus(if_a.slave)
  );

  commit_control #(.DATA_WIDTH(16), .TAG_WIDTH(3), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(rst_n_b), .bus(if_b.slave)
  );

  assign if_b.head_valid   = if_a.head_valid;
  assign if_b.head_opcode  = if_a.head_opcode;
  assign if_b.head_dest    = if_a.head_dest;
  assign if_b.head_value   = if_a.head_value;
  assign if_b.head_predict = if_a.head_predict;
  assign if_b.head_addr    = if_a.head_addr;
  assign if_b.rat_tag      = if_a.rat_tag;
  assign if_b.trap_reg     = if_a.trap_reg;
  assign if_b.dmem_resp    = if_a.dmem_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic v, input lc3b_opcode op, input lc3b_reg d,
                          input logic [15:0] val, input logic pred);
    if_a.head_valid   = v;
    if_a.head_opcode  = op;
    if_a.head_dest    = d;
    if_a.head_value   = val;
    if_a.head_predict = pred;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n_a     = 1'b0;
    rst_n_b     = 1'b0;
    if_a.head_addr = 3'd5;
    if_a.rat_tag   = 3'd5;
    if_a.trap_reg  = 16'h0000;
    if_a.dmem_resp = 1'b0;
    set_head(1'b1, OP_ADD, 3'd3, 16'h8000, 1'b0);

    // Reset: outputs low even with a valid head.
    #2;
    chk1("rst_rob_re", if_a.rob_re, 1'b0);
    chk1("rst_rf_ld_value", if_a.rf_ld_value, 1'b0);
    tick();
    tick();
    chk("rst_cnt_retired", if_a.cnt_retired, 32'd0);
    chk("rst_cnt_branch", if_a.cnt_branch, 32'd0);

    // ADD R3 <- 8000 with matching tag.
    rst_n_a = 1'b1;
    #1;
    chk1("add_ld_value", if_a.rf_ld_value, 1'b1);
    chk1("add_ld_busy", if_a.rf_ld_busy, 1'b1);
    chk1("add_rob_re", if_a.rob_re, 1'b1);
    chk("add_rf_dest", 32'(if_a.rf_dest), 32'd3);
    chk("add_rf_value", 32'(if_a.rf_value), 32'h8000);
    tick();

    // BR n, predicted taken: CC is n, so correct prediction.
    set_head(1'b1, OP_BR, 3'b100, 16'h2000, 1'b1);
    #1;
    chk1("br_n_pred_ld", if_a.pred_ld, 1'b1);
    chk1("br_n_taken", if_a.pred_taken, 1'b1);
    chk1("br_n_flush", if_a.flush, 1'b0);
    chk1("br_n_rob_re", if_a.rob_re, 1'b1);
    tick();

    // ADD value 0 with non-matching tag: write but no busy clear, CC -> z.
    set_head(1'b1, OP_ADD, 3'd1, 16'h0000, 1'b0);
    if_a.rat_tag = 3'd2;
    #1;
    chk1("add2_ld_value", if_a.rf_ld_value, 1'b1);
    chk1("add2_ld_busy", if_a.rf_ld_busy, 1'b0);
    tick();
    if_a.rat_tag = 3'd5;

    // BR z predicted not-taken: mispredict, redirect, 3-cycle flush.
    set_head(1'b1, OP_BR, 3'b010, 16'h3000, 1'b0);
    #1;
    chk1("mis_flush0", if_a.flush, 1'b1);
    chk1("mis_pcmux", if_a.pcmux_sel, 1'b1);
    chk("mis_new_pc", 32'(if_a.new_pc), 32'h3000);
    chk1("mis_taken", if_a.pred_taken, 1'b1);
    chk1("mis_rob_re", if_a.rob_re, 1'b1);
    tick();
    set_head(1'b1, OP_ADD, 3'd4, 16'h0005, 1'b0);
    #1;
    chk1("mis_flush1", if_a.flush, 1'b1);
    chk1("mis_flush1_rob_re", if_a.rob_re, 1'b0);
    chk1("mis_flush1_pcmux", if_a.pcmux_sel, 1'b0);
    chk1("mis_flush1_ld", if_a.rf_ld_value, 1'b0);
    tick();
    #1;
    chk1("mis_flush2", if_a.flush, 1'b1);
    chk1("mis_flush2_rob_re", if_a.rob_re, 1'b0);
    tick();
    if_a.head_valid = 1'b0;
    #1;
    chk1("mis_flush3", if_a.flush, 1'b0);
    chk("mis_cnt_retired", if_a.cnt_retired, 32'd4);
    chk("mis_cnt_branch", if_a.cnt_branch, 32'd2);
    chk("mis_cnt_mispredict", if_a.cnt_mispredict, 32'd1);
    tick();

    // BR p with CC still z, predicted not-taken: correct.
    set_head(1'b1, OP_BR, 3'b001, 16'h4000, 1'b0);
    #1;
    chk1("br_p_pred_ld", if_a.pred_ld, 1'b1);
    chk1("br_p_taken", if_a.pred_taken, 1'b0);
    chk1("br_p_flush", if_a.flush, 1'b0);
    tick();

    // TRAP: link from trap_reg, redirect to head_value, then flush.
    set_head(1'b1, OP_TRAP, 3'd7, 16'h0040, 1'b0);
    if_a.trap_reg = 16'h1234;
    #1;
    chk("trap_rf_value", 32'(if_a.rf_value), 32'h1234);
    chk1("trap_ld_value", if_a.rf_ld_value, 1'b1);
    chk1("trap_flush", if_a.flush, 1'b1);
    chk("trap_new_pc", 32'(if_a.new_pc), 32'h0040);
    tick();
    if_a.head_valid = 1'b0;
    #1;
    chk1("trap_flush1", if_a.flush, 1'b1);
    tick();
    tick();
    chk1("trap_flush_done", if_a.flush, 1'b0);
    chk("trap_cnt_mispredict", if_a.cnt_mispredict, 32'd1);
    chk("trap_cnt_retired", if_a.cnt_retired, 32'd6);

    // STR with response in the 5th cycle.
    set_head(1'b1, OP_STR, 3'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if_a.dmem_resp = (i == 4);
      #1;
      chk1("str_dmem_write", if_a.dmem_write, 1'b1);
      chk1("str_rob_re", if_a.rob_re, (i == 4));
      chk1("str_ldstr_re", if_a.ldstr_re, (i == 4));
      tick();
    end
    if_a.dmem_resp = 1'b0;

    // ADD 1 sets CC=p, then LDI pair writes 0 and sets CC=z.
    set_head(1'b1, OP_ADD, 3'd6, 16'h0001, 1'b0);
    tick();
    set_head(1'b1, OP_LDI, 3'd2, 16'h1000, 1'b0);
    #1;
    chk1("ldi1_rob_re", if_a.rob_re, 1'b1);
    chk1("ldi1_ld_value", if_a.rf_ld_value, 1'b0);
    tick();
    if_a.head_valid = 1'b0;
    #1;
    chk1("ldi2_wait_rob_re", if_a.rob_re, 1'b0);
    tick();
    set_head(1'b1, OP_LDI, 3'd2, 16'h0000, 1'b0);
    #1;
    chk1("ldi2_ld_value", if_a.rf_ld_value, 1'b1);
    chk1("ldi2_rob_re", if_a.rob_re, 1'b1);
    chk("ldi2_rf_dest", 32'(if_a.rf_dest), 32'd2);
    tick();
    set_head(1'b1, OP_BR, 3'b010, 16'h5000, 1'b1);
    #1;
    chk1("ldi_cc_z_taken", if_a.pred_taken, 1'b1);
    chk1("ldi_cc_z_flush", if_a.flush, 1'b0);
    tick();

    // STI with response in STI2 while the head is not valid.
    set_head(1'b1, OP_STI, 3'd0, 16'h0000, 1'b0);
    #1;
    chk1("sti1_rob_re", if_a.rob_re, 1'b1);
    chk1("sti1_dmem_write", if_a.dmem_write, 1'b0);
    tick();
    if_a.head_valid = 1'b0;
    if_a.dmem_resp  = 1'b1;
    #1;
    chk1("sti2_dmem_write", if_a.dmem_write, 1'b1);
    chk1("sti2_rob_re", if_a.rob_re, 1'b1);
    chk1("sti2_ldstr_re", if_a.ldstr_re, 1'b1);
    tick();
    if_a.dmem_resp = 1'b0;
    #1;
    chk1("sti_done_dmem_write", if_a.dmem_write, 1'b0);
    chk("sti_cnt_retired", if_a.cnt_retired, 32'd13);
    tick();

    // STI then reset during STI2.
    set_head(1'b1, OP_STI, 3'd0, 16'h0000, 1'b0);
    tick();
    if_a.head_valid = 1'b0;
    #1;
    chk1("sti_rst_pre_dmem_write", if_a.dmem_write, 1'b1);
    chk1("sti_rst_pre_rob_re", if_a.rob_re, 1'b0);
    rst_n_a = 1'b0;
    #1;
    chk1("sti_rst_drop", if_a.dmem_write, 1'b0);
    tick();
    rst_n_a = 1'b1;
    #1;
    chk1("post_rst_dmem_write", if_a.dmem_write, 1'b0);
    chk1("post_rst_rob_re", if_a.rob_re, 1'b0);
    chk1("post_rst_flush", if_a.flush, 1'b0);
    chk("post_rst_cnt_retired", if_a.cnt_retired, 32'd0);
    tick();

    // Saturation on the 4-bit counter instance.
    rst_n_b = 1'b1;
    set_head(1'b1, OP_ADD, 3'd1, 16'h0001, 1'b0);
    #1;
    chk("sat_start", 32'(if_b.cnt_retired), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(if_b.cnt_retired), 32'd14);
    tick();
    chk("sat_15", 32'(if_b.cnt_retired), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 32'(if_b.cnt_retired), 32'd15);
    chk("sat_branch", 32'(if_b.cnt_branch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
